prediction_tracker: RTL

Initiator side of the prediction bus: issues lookups on behalf of the fetch stage, keeps every unresolved prediction in an in-order buffer, and drives the update channel (outcome, rollback) as branches resolve. Sits between fetch/execute and any predictor on the bus, e.g. the tournament predictor. Owns `is_stalling`, so it provides the backpressure for the whole prediction path.

---
 rtl/prediction_tracker.sv | 116 +++++++++++
 1 files changed

// File: rtl/prediction_tracker.sv
// Initiator side of the prediction bus: tracks in-flight predictions in order and drives
// outcome/rollback updates as branches resolve. Define PRED_TRACKER_STATS_EN for pop/rollback counters.
module prediction_tracker #(
  parameter int INDEX_LEN = 10,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_valid,
  input  logic [INDEX_LEN-1:0]         fetch_index,
  output logic                         fetch_take,
  input  logic                         resolve_valid,
  input  logic                         resolve_taken,
  output logic [INDEX_LEN-1:0]         query_index,
  input  logic                         resp_take,
  output logic                         upd_enable,
  output logic [INDEX_LEN-1:0]         upd_index,
  output logic                         upd_taken,
  output logic                         upd_is_rollback,
  output logic                         is_stalling,
  output logic                         flush,
  output logic                         err_underflow,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PRED_TRACKER_STATS_EN
  ,
  output logic [31:0]                  stat_predictions,
  output logic [31:0]                  stat_rollbacks
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [INDEX_LEN-1:0] idx_mem [DEPTH];
  logic                 pred_mem [DEPTH];

  logic [INDEX_LEN-1:0] head_index;
  logic                 head_pred;
  logic                 pop;
  logic                 mispredict;
  logic                 correct_pop;
  logic                 full;
  logic                 push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake: fetch is accepted when fetch_valid && !is_stalling (and the same-cycle
  // resolve is not a mispredict); a resolve pops the head when the buffer is non-empty.
  assign query_index = fetch_index;
  assign fetch_take  = resp_take;
  assign head_index  = idx_mem[rd_ptr];
  assign head_pred   = pred_mem[rd_ptr];
  assign pop         = resolve_valid && (count != '0);
  assign mispredict  = pop && (resolve_taken != head_pred);
  assign correct_pop = pop && !mispredict;
  assign full        = (count == CW'(DEPTH));
  assign is_stalling = flush || (full && !correct_pop);
  assign push        = fetch_valid && !is_stalling && !mispredict;
  assign occupancy   = count;

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr]  <= fetch_index;
      pred_mem[wr_ptr] <= resp_take;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      upd_enable      <= 1'b0;
      upd_index       <= '0;
      upd_taken       <= 1'b0;
      upd_is_rollback <= 1'b0;
      flush           <= 1'b0;
      err_underflow   <= 1'b0;
    end else begin
      // A mispredict discards every younger entry: the buffer restarts empty after the head.
      if (mispredict) begin
        count  <= '0;
        rd_ptr <= next_ptr(rd_ptr);
        wr_ptr <= next_ptr(rd_ptr);
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
      upd_enable      <= pop;
      upd_index       <= pop ? head_index : '0;
      upd_taken       <= pop && resolve_taken;
      upd_is_rollback <= mispredict;
      flush           <= mispredict;
      err_underflow   <= err_underflow || (resolve_valid && (count == '0));
    end
  end

`ifdef PRED_TRACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_predictions <= '0;
      stat_rollbacks   <= '0;
    end else begin
      stat_predictions <= stat_predictions + {31'd0, pop};
      stat_rollbacks   <= stat_rollbacks + {31'd0, mispredict};
    end
  end
`endif

endmodule
